// File: rtl/adler32_check_if.sv
// Byte-stream handshake into the Adler-32 checker.
// Transfer happens on data_valid & in_ready.
interface adler32_check_if;
    logic       data_valid;
    logic       last_data;
    logic [7:0] data;
    logic       in_ready;

    modport master (
        output data_valid,
        output last_data,
        output data,
        input  in_ready
    );

    modport slave (
        input  data_valid,
        input  last_data,
        input  data,
        output in_ready
    );
endinterface

// File: rtl/adler32_check.sv
// Adler-32 payload checker: sums payload, captures 4-byte big-endian trailer, compares.
// Optional ADLER32_CHECK_ERRCNT_EN adds a saturating mismatch counter (err_count).
module adler32_check #(
    parameter int unsigned MODULUS = 65521
) (
    input  logic          clock,
    input  logic          rst,
    adler32_check_if.slave bus,
    output logic          check_done,
    output logic          check_pass,
    output logic [31:0]   checksum
`ifdef ADLER32_CHECK_ERRCNT_EN
    ,
    output logic [15:0]   err_count
`endif
);

    typedef enum logic [1:0] {
        PAYLOAD = 2'd0,
        TRAILER = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [16:0] MOD17 = 17'(MODULUS);

    state_t      state;
    state_t      state_d;
    logic [15:0] a;
    logic [15:0] a_d;
    logic [15:0] b;
    logic [15:0] b_d;
    logic [15:0] a_acc;
    logic [15:0] b_acc;
    logic [31:0] trl;
    logic [31:0] trl_d;
    logic [1:0]  idx;
    logic [1:0]  idx_d;
    logic        pass_q;
    logic        pass_d;
    logic        take;

    // Both operands are below MODULUS, so one subtract fully reduces.
    function automatic logic [15:0] mod_add(
        input logic [15:0] x,
        input logic [15:0] y
    );
        logic [16:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= MOD17) begin
            s = s - MOD17;
        end
        return s[15:0];
    endfunction

    assign bus.in_ready = (state != DONE);
    assign take         = bus.data_valid & bus.in_ready;
    assign check_done   = (state == DONE);
    assign check_pass   = pass_q;
    assign checksum     = {b, a};

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state  <= PAYLOAD;
            a      <= 16'h0001;
            b      <= 16'h0000;
            trl    <= 32'h0;
            idx    <= 2'd0;
            pass_q <= 1'b0;
        end else begin
            state  <= state_d;
            a      <= a_d;
            b      <= b_d;
            trl    <= trl_d;
            idx    <= idx_d;
            pass_q <= pass_d;
        end
    end

    always_comb begin
        state_d = state;
        a_d     = a;
        b_d     = b;
        trl_d   = trl;
        idx_d   = idx;
        pass_d  = pass_q;
        a_acc   = mod_add(a, {8'h00, bus.data});
        b_acc   = mod_add(b, a_acc);
        unique case (state)
            PAYLOAD: begin
                if (take) begin
                    a_d = a_acc;
                    b_d = b_acc;
                    if (bus.last_data) begin
                        state_d = TRAILER;
                    end
                end
            end
            TRAILER: begin
                if (take) begin
                    // ~idx == 3-idx: first trailer byte lands in [31:24]
                    trl_d[{~idx, 3'b000} +: 8] = bus.data;
                    idx_d = idx + 2'd1;
                    if (idx == 2'd3) begin
                        state_d = DONE;
                        pass_d  = (trl_d == {b, a});
                    end
                end
            end
            DONE: begin
                state_d = PAYLOAD;
                a_d     = 16'h0001;
                b_d     = 16'h0000;
                idx_d   = 2'd0;
            end
            default: begin
                state_d = PAYLOAD;
            end
        endcase
    end

`ifdef ADLER32_CHECK_ERRCNT_EN
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            err_count <= 16'h0000;
        end else if (check_done && !pass_q && err_count != 16'hFFFF) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/adler32_check.md
ADLER32_CHECK -- requirements
Module: adler32_check

Interface
REQ-001 SHALL have parameter MODULUS, default 65521, Adler-32 reduction modulus (16-bit, >255).
REQ-002 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port data_valid  input  1  byte on data is offered this cycle.
REQ-005 SHALL have port last_data  input  1  qualifies the offered byte as the final payload byte.
REQ-006 SHALL have port data  input  8  payload or trailer byte.
REQ-007 SHALL have port in_ready  output  1  block accepts a byte this cycle; transfer = data_valid & in_ready.
REQ-008 SHALL have port check_done  output  1  one-cycle pulse; check_pass is valid in that cycle.
REQ-009 SHALL have port check_pass  output  1  received trailer equals computed checksum.
REQ-010 SHALL have port checksum  output  32  computed checksum {B[15:0],A[15:0]}, held after payload end.

Function
REQ-011 SHALL run FSM states PAYLOAD, TRAILER, DONE; reset state PAYLOAD.
REQ-012 SHALL, in PAYLOAD per accepted byte, update A' = (A + data) mod MODULUS and B' = (B + A') mod MODULUS in the same cycle.
REQ-013 SHALL reduce each sum with one 17-bit add and one conditional subtract of MODULUS (sum >= MODULUS), with no divider.
REQ-014 SHALL move PAYLOAD->TRAILER on an accepted byte with last_data=1, with that byte included in A/B.
REQ-015 SHALL, in TRAILER, capture 4 accepted bytes big-endian (first byte = checksum[31:24]) with a 2-bit index, and leave A/B unchanged.
REQ-016 SHALL ignore last_data in TRAILER and DONE.
REQ-017 SHALL move TRAILER->DONE on acceptance of the 4th trailer byte.
REQ-018 SHALL drive check_done=1 for exactly the single DONE cycle, with check_pass = (trailer == checksum), which is 1 cycle after the last trailer byte.
REQ-019 SHALL drive in_ready=0 in DONE and 1 in PAYLOAD and TRAILER; data_valid offered in DONE is not consumed.
REQ-020 SHALL go DONE->PAYLOAD unconditionally, re-initialising A=1 and B=0 on that edge; the next message may start the following cycle.
REQ-021 SHALL hold check_pass at its last value outside check_done, and SHALL hold A, B and the trailer index on data_valid=0 cycles (gaps allowed anywhere).
REQ-022 SHALL treat a single-byte payload (first byte with last_data=1) as legal.

Reset
REQ-023 SHALL, while rst=1 (asynchronous), force state=PAYLOAD, A=1, B=0, trailer register=0, index=0, check_done=0, check_pass=0, in_ready=1 (after release), and checksum=0x00000001.
REQ-024 SHALL discard a partial message on reset mid-message, with no check_done issued for it.

Configuration
REQ-025 SHALL, with ADLER32_CHECK_ERRCNT_EN defined, add output err_count (16-bit) that increments on each check_done with check_pass=0, saturates at 0xFFFF, and resets to 0.
REQ-026 SHALL, without ADLER32_CHECK_ERRCNT_EN, have no err_count port or counter logic and leave all other behaviour identical.

Verification
REQ-027 SHALL pass: payload "abc" (0x61,0x62,0x63, last on 0x63) then trailer 02 4D 01 27 -> checksum=0x024D0127, check_done pulse 1 cycle after 4th trailer byte, check_pass=1.
REQ-028 SHALL pass: payload 0x61 single byte with last_data=1, trailer 00 62 00 62 -> check_pass=1; repeat with trailer 00 62 00 63 -> check_pass=0, err_count=1 when ERRCNT enabled.
REQ-029 SHALL pass: "Wikipedia" with 1-3 idle cycles randomly inserted, trailer 11 E6 03 98 -> check_pass=1 and result identical to the gap-free run.
REQ-030 SHALL pass: 257 bytes of 0xFF -> checksum[15:0]=0x000F (modulus wrap), B matching a software model, check_pass=1 with the model's trailer.
REQ-031 SHALL pass: back-to-back messages with data_valid held high -> in_ready=0 exactly in each DONE cycle, no byte lost, and the second message result independent of the first.
REQ-032 SHALL pass: rst asserted after 2 trailer bytes -> no check_done, checksum=0x00000001, next message checks correctly.
